nn_layer_sequencer: RTL
=======================

NN_LAYER_SEQUENCER -- requirements
Module: nn_layer_sequencer

Interface
REQ-001 Parameter N_IN, default 8: inputs per neuron; power of 2, 2..16.
REQ-002 Parameter N_OUT, default 4: neurons; power of 2, 1..8.
REQ-003 Parameter ACC_W, default 5: signed accumulator width; SHALL be at least clog2(N_IN)+2.
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst_n  in  1  synchronous, active-low reset.
REQ-006 ena  in  1  design enable; low stalls all state.
REQ-007 cfg_we  in  1  weight write strobe.
REQ-008 cfg_addr  in  clog2(N_IN*N_OUT)  weight index = j*N_IN + i (neuron j, input i).
REQ-009 cfg_wdata  in  2  {w_sign, w_zero}; w_zero=1 -> weight 0; else w_sign=0 -> +1, w_sign=1 -> -1.
REQ-010 threshold  in  ACC_W  signed activation threshold, sampled at start.
REQ-011 start  in  1  begin inference; level-sampled in IDLE.
REQ-012 x_in  in  N_IN  binary input vector, sampled at start.
REQ-013 busy  out  1  high in RUN and DONE.
REQ-014 done  out  1  single-cycle pulse when y_out updates.
REQ-015 y_out  out  N_OUT  binary neuron outputs; held until next done.

Function
REQ-016 FSM states IDLE, RUN, DONE; one state transition per enabled cycle.
REQ-017 IDLE: start=1 latches x_in and threshold, clears acc, sets i=0, j=0, and moves to RUN.
REQ-018 RUN: each cycle processes one pair (j,i): acc += x[i] ? w(j,i) : 0.
REQ-019 Index order: i increments; at i=N_IN-1, i wraps to 0 and j increments.
REQ-020 At i=N_IN-1: y_next[j] = (acc_final > threshold), signed compare; acc cleared for the next neuron.
REQ-021 After pair (N_OUT-1, N_IN-1): go to DONE.
REQ-022 DONE lasts one cycle: y_out <= y_next, done=1, then IDLE.
REQ-023 Latency: done high exactly N_IN*N_OUT+1 enabled cycles after the start-sampling edge (default 33).
REQ-024 y_out changes only in the DONE cycle; intermediate results never appear on y_out.
REQ-025 Accumulator never overflows: |acc| <= N_IN fits in ACC_W; no saturation logic.
REQ-026 cfg_we in IDLE: writes cfg_wdata to cfg_addr on that edge.
REQ-027 cfg_we while busy: write is dropped; weight memory unchanged.
REQ-028 start while busy: ignored; no restart, no queuing.
REQ-029 start and cfg_we together in IDLE: both take effect; the run uses the newly written weight.
REQ-030 ena=0: FSM, counters, acc, weights, y_out and latched inputs all hold; done=0 while ena=0.
REQ-031 done is registered; busy is decoded from the state register.

Reset
REQ-032 rst_n=0 at a rising edge: state=IDLE, i=j=0, acc=0, y_out=0, done=0, busy=0.
REQ-033 Reset sets all weights to 0 (w_zero=1); reset overrides ena.
REQ-034 Reset mid-RUN aborts the run with no done pulse; y_out=0 on the following cycle.

Verification
REQ-035 After reset, threshold=0, x_in=8'hFF, start -> done at cycle 33, y_out=4'b0000.
REQ-036 Neuron 0 weights all +1, x_in=8'hFF, threshold=7 (acc=8) -> y_out=4'b0001; with threshold=8 -> y_out=4'b0000.
REQ-037 Neuron 1 weights +1 at even i and -1 at odd i, x_in=8'h55 (acc=4): threshold=3 -> y_out[1]=1; threshold=4 -> y_out[1]=0.
REQ-038 Neuron 2 weights all -1, x_in=8'hFF (acc=-8): threshold=-8 -> y_out[2]=0; threshold=-9 -> y_out[2]=1.
REQ-039 Mid-run: start pulse plus cfg_we to addr 0 -> no restart and weight unchanged; ena=0 for 5 cycles -> done at cycle 38.
REQ-040 rst_n=0 at cycle 10 of a run -> busy=0 next cycle, y_out=0, no done pulse; new run with x_in=8'hFF -> y_out=0 (all weights 0).

Source files
------------

// File: rtl/nn_layer_sequencer.sv
// +--------------------------------------------------------------------------+
// | nn_layer_sequencer                                                       |
// | Ternary-weight binary neuron layer, one (neuron,input) pair per cycle.   |
// | Revision: 1.0                                                            |
// +--------------------------------------------------------------------------+
`default_nettype none

module nn_layer_sequencer #(
  parameter int N_IN  = 8,
  parameter int N_OUT = 4,
  parameter int ACC_W = 5
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic                            ena,
  input  logic                            cfg_we,
  input  logic [$clog2(N_IN*N_OUT)-1:0]   cfg_addr,
  input  logic [1:0]                      cfg_wdata,
  input  logic signed [ACC_W-1:0]         threshold,
  input  logic                            start,
  input  logic [N_IN-1:0]                 x_in,
  output logic                            busy,
  output logic                            done,
  output logic [N_OUT-1:0]                y_out
);

  localparam int c_AW   = $clog2(N_IN*N_OUT);
  localparam int c_IW   = $clog2(N_IN);
  localparam int c_JW   = (N_OUT > 1) ? $clog2(N_OUT) : 1;
  localparam int c_NW   = N_IN * N_OUT;
  localparam logic [c_IW-1:0] c_I_LAST = c_IW'(N_IN - 1);
  localparam logic [c_JW-1:0] c_J_LAST = c_JW'(N_OUT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                    r_state;
  logic [c_NW-1:0]           r_w_zero;
  logic [c_NW-1:0]           r_w_sign;
  logic [c_IW-1:0]           r_i;
  logic [c_JW-1:0]           r_j;
  logic [N_IN-1:0]           r_x;
  logic signed [ACC_W-1:0]   r_thr;
  logic signed [ACC_W-1:0]   r_acc;
  logic [N_OUT-1:0]          r_y_next;
  logic [N_OUT-1:0]          r_y;
  logic                      r_done;

  logic [c_AW-1:0]           w_addr;
  logic signed [ACC_W-1:0]   w_term;
  logic signed [ACC_W-1:0]   w_acc_next;
  logic                      w_fire;

  assign w_addr = c_AW'(int'(r_j) * N_IN + int'(r_i));

  always_comb begin
    w_term = '0;
    if (r_x[r_i] && !r_w_zero[w_addr]) begin
      w_term = r_w_sign[w_addr] ? {ACC_W{1'b1}} : ACC_W'(1);
    end
  end

  assign w_acc_next = r_acc + w_term;
  assign w_fire     = (w_acc_next > r_thr);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_w_zero <= '1;
      r_w_sign <= '0;
      r_i      <= '0;
      r_j      <= '0;
      r_x      <= '0;
      r_thr    <= '0;
      r_acc    <= '0;
      r_y_next <= '0;
      r_y      <= '0;
      r_done   <= 1'b0;
    end else begin
      r_done <= 1'b0;
      if (ena) begin
        case (r_state)
          S_IDLE: begin
            // Weight write lands on this edge, so a same-cycle start sees it.
            if (cfg_we) begin
              r_w_zero[cfg_addr] <= cfg_wdata[0];
              r_w_sign[cfg_addr] <= cfg_wdata[1];
            end
            if (start) begin
              r_x     <= x_in;
              r_thr   <= threshold;
              r_acc   <= '0;
              r_i     <= '0;
              r_j     <= '0;
              r_state <= S_RUN;
            end
          end
          S_RUN: begin
            if (r_i == c_I_LAST) begin
              r_y_next[r_j] <= w_fire;
              r_acc         <= '0;
              r_i           <= '0;
              if (r_j == c_J_LAST) begin
                r_j     <= '0;
                r_state <= S_DONE;
              end else begin
                r_j <= r_j + 1'b1;
              end
            end else begin
              r_acc <= w_acc_next;
              r_i   <= r_i + 1'b1;
            end
          end
          S_DONE: begin
            r_y     <= r_y_next;
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
          default: r_state <= S_IDLE;
        endcase
      end
    end
  end

  assign busy  = (r_state != S_IDLE);
  assign done  = r_done;
  assign y_out = r_y;

endmodule

`default_nettype wire
